// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshakes: single-cycle logic/arith ops and
// an iterative shift-add multiplier that occupies the block for WIDTH cycles.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Opcode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       fsm_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never waits on ready, and the result holds while out_valid
  // is 1 and out_ready is 0.

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic               accept;
  logic               is_mul;
  logic               mul_last;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_next;
  logic [SW-1:0]      cnt;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH:0]     shl;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_o;
  logic               alu_e;
  logic               alu_z;
  logic               alu_n;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign fsm_state = state;
  assign accept    = in_valid && in_ready;
  assign is_mul    = (Opcode == 3'b110);
  assign mul_last  = (state == BUSY) && (cnt == SW'(WIDTH - 1));
  assign prod_next = prod + (mplier[0] ? mcand : '0);

  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};
  // One spare bit above the result catches the last bit shifted out.
  assign shl  = {1'b0, A} << B[SW-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    alu_e   = 1'b0;
    case (Opcode)
      3'b000: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_o   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      3'b001: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_o   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      3'b010: alu_res = A & B;
      3'b011: alu_res = A | B;
      3'b100: alu_res = A ^ B;
      3'b101: begin
        alu_res = shl[WIDTH-1:0];
        alu_c   = shl[WIDTH];
      end
      3'b111: alu_e = 1'b1;
      default: alu_res = '0;
    endcase
  end

  // The reserved opcode reports only err, so zero is suppressed there.
  assign alu_z = !alu_e && (alu_res == '0);
  assign alu_n = alu_res[WIDTH-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = is_mul ? BUSY : DONE;
    end else begin
      case (state)
        BUSY:    if (mul_last) state_next = DONE;
        DONE:    if (out_ready) state_next = IDLE;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
      err    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else if (accept && !is_mul) begin
      result <= alu_res;
      carry  <= alu_c;
      zero   <= alu_z;
      neg    <= alu_n;
      ovf    <= alu_o;
      err    <= alu_e;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, A};
      mplier <= B;
      prod   <= '0;
      cnt    <= '0;
    end else if (state == BUSY) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      prod   <= prod_next;
      cnt    <= cnt + SW'(1);
      if (mul_last) begin
        result <= prod_next[WIDTH-1:0];
        carry  <= 1'b0;
        zero   <= (prod_next[WIDTH-1:0] == '0);
        neg    <= prod_next[WIDTH-1];
        ovf    <= |prod_next[2*WIDTH-1:WIDTH];
        err    <= 1'b0;
      end
    end
  end

endmodule
